status_reg_bank: RTL and testbench
==================================

Name: status_reg_bank

Overview:
- Parametrised successor to the single NZCV status register in the EX stage.
- Holds NUM_CTX independent flag contexts, each written with a per-flag write mask.
- Provides a shared LIFO save/restore stack for exception entry and return.
- Evaluates LEGv8 B.cond condition codes against the selected context. The registered result feeds branch resolution.

Parameters:
- NUM_CTX, 2, number of flag contexts (hardware threads / exception levels); must be >= 1.
- STK_DEPTH, 4, flag save-stack entries; must be >= 1.
- CTX_W, $clog2(NUM_CTX) min 1, context select width (derived).
- PTR_W, $clog2(STK_DEPTH+1), stack occupancy counter width (derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ctx_sel  input  CTX_W  context addressed by every operation this cycle; values >= NUM_CTX are ignored (no write, outputs read context 0).
- flags_in  input  4  new flags {N,Z,V,C} from ALU.
- upd_en  input  1  update selected context.
- upd_mask  input  4  per-bit write enable, same order as flags_in.
- push  input  1  save selected context's flags onto stack.
- pop  input  1  restore top of stack into selected context.
- cond  input  4  LEGv8 condition code.
- cond_valid  input  1  request condition evaluation.
- flags_out  output  4  current {N,Z,V,C} of selected context (combinational read of register).
- cond_taken  output  1  registered evaluation result.
- cond_taken_valid  output  1  pulses one cycle after cond_valid.
- stk_level  output  PTR_W  current stack occupancy.
- stk_full  output  1  stk_level == STK_DEPTH.
- stk_empty  output  1  stk_level == 0.
- stk_err  output  2  sticky {overflow, underflow}.
- clear_err  input  1  clears stk_err.

Behaviour:
- Reset: all contexts 4'b0000; all stack entries 0; stk_level 0; stk_err 0; cond_taken 0; cond_taken_valid 0. Reset mid-operation discards every in-flight update, push and pop.
- Update: at the clock edge with upd_en, ctx[sel][i] <= upd_mask[i] ? flags_in[i] : ctx[sel][i]. One-cycle latency to flags_out. upd_mask == 0 leaves the context unchanged.
- Push, not full: entry[stk_level] <= ctx[sel] (pre-update value); stk_level + 1.
- Push, full: push dropped; stk_err[1] set.
- Pop, not empty: ctx[sel] <= entry[stk_level-1]; stk_level - 1. Pop overrides upd_en on the same context in the same cycle.
- Pop, empty: context unchanged; upd_en still applies; stk_err[0] set.
- Push and pop together, non-empty: exchange. ctx[sel] <= top entry, top entry <= old ctx[sel], stk_level unchanged.
- Push and pop together, empty: behaves as push only; stk_err[0] set.
- stk_err: sticky. clear_err clears it. A new error in the same cycle as clear_err wins (bit stays set).
- Condition evaluation uses the registered flags of ctx_sel. cond_taken registered on the edge after cond_valid:
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !(C&!Z)
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE !(GT)
  - 1110 AL 1; 1111 NV 1
- cond_taken holds its value when cond_valid is low; cond_taken_valid is 0 on those cycles.
- Back-to-back cond_valid: one result per cycle, no stall.

Optional Feature:
- Macro: STATUS_REG_BANK_BYPASS_EN.
- Defined: condition evaluation and flags_out see the same-cycle masked flags_in when upd_en targets ctx_sel (forwarding). A concurrent pop's restored value takes precedence over flags_in.
- Undefined: evaluation and flags_out see registered flags only; software/pipeline must insert one bubble between a flag-setting op and a dependent B.cond.

Decomposition:
- Shared package legv8_flags_pkg:
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
  - 4-bit condition code constants COND_EQ..COND_NV.
  - pure function cond_eval(cond, flags).
- Natural sub-module: flag_stack. Owns the storage array, stk_level, full/empty, the exchange case and the error bits. The bank instantiates one and keeps the context array plus condition logic.

Test Plan:
- Reset then upd_en ctx 1, flags_in 4'b1010, mask 4'b1111 -> next cycle ctx 1 flags_out 1010, ctx 0 still 0000.
- ctx 0 = 1111, upd_en flags_in 0000 mask 4'b0100 -> flags_out 1011.
- Push 5 times with STK_DEPTH=4 -> stk_full after 4th push, stk_err 2'b10 after 5th. Pop 4 times -> flags restored in reverse order, stk_empty. Extra pop -> stk_err 2'b11. clear_err -> 00.
- Flags {N,Z,V,C}=1001 (N=1, C=1), cond sweep 0000..1111 -> cond_taken = 0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,1, each one cycle after cond_valid.
- Push and pop together with top entry 0110 and ctx 0011 -> ctx 0110, top entry 0011, level unchanged. Same with upd_en -> pop value wins.
- BYPASS_EN: upd_en flags_in Z=1 with cond EQ same cycle -> cond_taken 1 next cycle. Without macro -> 0.

Source files
------------

// File: rtl/legv8_flags_pkg.sv
// Shared LEGv8 NZCV flag definitions: bit positions, B.cond codes and the
// condition evaluator used by the status register bank.
package legv8_flags_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, v, c, r;
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    v = flags[FLAG_V];
    c = flags[FLAG_C];
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_HS: r = c;
      COND_LO: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~(c & ~z);
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = ~(~z & (n == v));
      default: r = 1'b1; // AL and NV both always taken
    endcase
    return r;
  endfunction

endpackage

// File: rtl/status_reg_bank_flag_stack.sv
// LIFO save/restore stack for NZCV flags with exchange support and sticky
// {overflow, underflow} error bits.
module flag_stack
  import legv8_flags_pkg::*;
#(
  parameter int STK_DEPTH = 4,
  parameter int PTR_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       push_data,
  input  logic             clear_err,
  output logic [3:0]       pop_data,
  output logic             pop_ok,
  output logic [PTR_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic [1:0]       err
);

  logic [3:0]       entries_q [STK_DEPTH];
  logic [3:0]       entries_d [STK_DEPTH];
  logic [PTR_W-1:0] level_q, level_d;
  logic [1:0]       err_q, err_d;
  logic             xchg, do_push, do_pop, ovf, udf;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == PTR_W'(STK_DEPTH));
    xchg    = push & pop & ~empty;
    do_push = push & ~full & ~(pop & ~empty);
    do_pop  = pop & ~push & ~empty;
    ovf     = push & ~pop & full;
    udf     = pop & empty;

    pop_data = '0;
    for (int i = 0; i < STK_DEPTH; i++)
      if (PTR_W'(i + 1) == level_q) pop_data = entries_q[i];

    entries_d = entries_q;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (xchg && PTR_W'(i + 1) == level_q) entries_d[i] = push_data;
      if (do_push && PTR_W'(i) == level_q)  entries_d[i] = push_data;
    end

    level_d = level_q;
    if (do_push)     level_d = level_q + PTR_W'(1);
    else if (do_pop) level_d = level_q - PTR_W'(1);

    // an error raised in the same cycle as clear_err survives the clear
    err_d = clear_err ? {ovf, udf} : (err_q | {ovf, udf});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STK_DEPTH; i++) entries_q[i] <= '0;
      level_q <= '0;
      err_q   <= '0;
    end else begin
      entries_q <= entries_d;
      level_q   <= level_d;
      err_q     <= err_d;
    end
  end

  assign pop_ok = pop & ~empty;
  assign level  = level_q;
  assign err    = err_q;

endmodule

// File: rtl/status_reg_bank.sv
// Multi-context NZCV status register bank with save stack and registered
// B.cond evaluation. Define STATUS_REG_BANK_BYPASS_EN to forward same-cycle flags.
module status_reg_bank
  import legv8_flags_pkg::*;
#(
  parameter int NUM_CTX   = 2,
  parameter int STK_DEPTH = 4,
  parameter int CTX_W     = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
  parameter int PTR_W     = $clog2(STK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CTX_W-1:0] ctx_sel,
  input  logic [3:0]       flags_in,
  input  logic             upd_en,
  input  logic [3:0]       upd_mask,
  input  logic             push,
  input  logic             pop,
  input  logic [3:0]       cond,
  input  logic             cond_valid,
  input  logic             clear_err,
  output logic [3:0]       flags_out,
  output logic             cond_taken,
  output logic             cond_taken_valid,
  output logic [PTR_W-1:0] stk_level,
  output logic             stk_full,
  output logic             stk_empty,
  output logic [1:0]       stk_err
);

  logic [3:0] ctx_q [NUM_CTX];
  logic [3:0] ctx_d [NUM_CTX];
  logic       cond_taken_q, cond_taken_d;
  logic       cond_taken_valid_q, cond_taken_valid_d;

  logic       sel_ok;
  logic [3:0] cur_flags, upd_val, sel_nxt, eval_flags;
  logic [3:0] stk_pop_data;
  logic       stk_pop_ok;

  flag_stack #(
    .STK_DEPTH(STK_DEPTH),
    .PTR_W    (PTR_W)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push & sel_ok),
    .pop      (pop & sel_ok),
    .push_data(cur_flags),
    .clear_err(clear_err),
    .pop_data (stk_pop_data),
    .pop_ok   (stk_pop_ok),
    .level    (stk_level),
    .full     (stk_full),
    .empty    (stk_empty),
    .err      (stk_err)
  );

  always_comb begin
    sel_ok = (int'(ctx_sel) < NUM_CTX);

    // out-of-range selects read context 0
    cur_flags = ctx_q[0];
    for (int i = 0; i < NUM_CTX; i++)
      if (sel_ok && CTX_W'(i) == ctx_sel) cur_flags = ctx_q[i];

    upd_val = (cur_flags & ~upd_mask) | (flags_in & upd_mask);

    if (stk_pop_ok)  sel_nxt = stk_pop_data;
    else if (upd_en) sel_nxt = upd_val;
    else             sel_nxt = cur_flags;

    ctx_d = ctx_q;
    for (int i = 0; i < NUM_CTX; i++)
      if (sel_ok && CTX_W'(i) == ctx_sel) ctx_d[i] = sel_nxt;

`ifdef STATUS_REG_BANK_BYPASS_EN
    eval_flags = sel_ok ? sel_nxt : cur_flags;
`else
    eval_flags = cur_flags;
`endif

    cond_taken_d       = cond_valid ? cond_eval(cond, eval_flags) : cond_taken_q;
    cond_taken_valid_d = cond_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) ctx_q[i] <= '0;
      cond_taken_q       <= 1'b0;
      cond_taken_valid_q <= 1'b0;
    end else begin
      ctx_q              <= ctx_d;
      cond_taken_q       <= cond_taken_d;
      cond_taken_valid_q <= cond_taken_valid_d;
    end
  end

  assign flags_out        = eval_flags;
  assign cond_taken       = cond_taken_q;
  assign cond_taken_valid = cond_taken_valid_q;

endmodule

// File: tb/tb_status_reg_bank.sv
// Self-checking bench for status_reg_bank: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_status_reg_bank;

  localparam int NUM_CTX   = 2;
  localparam int STK_DEPTH = 4;
  localparam int CTX_W     = 1;
  localparam int PTR_W     = 3;
`ifdef STATUS_REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [CTX_W-1:0] ctx_sel;
  logic [3:0]       flags_in, upd_mask, cond;
  logic             upd_en, push, pop, cond_valid, clear_err;
  logic [3:0]       flags_out;
  logic             cond_taken, cond_taken_valid, stk_full, stk_empty;
  logic [PTR_W-1:0] stk_level;
  logic [1:0]       stk_err;

  status_reg_bank #(.NUM_CTX(NUM_CTX), .STK_DEPTH(STK_DEPTH)) dut (
    .clk(clk), .rst(rst), .ctx_sel(ctx_sel), .flags_in(flags_in),
    .upd_en(upd_en), .upd_mask(upd_mask), .push(push), .pop(pop),
    .cond(cond), .cond_valid(cond_valid), .clear_err(clear_err),
    .flags_out(flags_out), .cond_taken(cond_taken),
    .cond_taken_valid(cond_taken_valid), .stk_level(stk_level),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [3:0] m_ctx [NUM_CTX];
  logic [3:0] m_stk [$];
  logic [1:0] m_err;
  logic       m_ct, m_ctv;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // pairs of codes share a base test; odd codes invert it, except NV
  function automatic logic ref_cond(logic [3:0] cc, logic [3:0] f);
    logic n, z, v, c, r;
    {n, z, v, c} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cc[0] && cc != 4'hF) r = !r;
    return r;
  endfunction

  function automatic bit m_ok();
    return int'(ctx_sel) < NUM_CTX;
  endfunction

  function automatic logic [3:0] m_cur();
    return m_ok() ? m_ctx[ctx_sel] : m_ctx[0];
  endfunction

  function automatic logic [3:0] m_next();
    logic [3:0] cur;
    cur = m_cur();
    if (!m_ok()) return cur;
    if (pop && m_stk.size() > 0) return m_stk[$];
    if (upd_en) return (cur & ~upd_mask) | (flags_in & upd_mask);
    return cur;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_CTX; i++) m_ctx[i] = 4'h0;
    m_stk.delete();
    m_err = 2'b00;
    m_ct  = 1'b0;
    m_ctv = 1'b0;
  endfunction

  function automatic void model_update();
    logic [3:0] cur, nxt;
    logic ovf, udf;
    int sz;
    if (rst) begin
      model_reset();
      return;
    end
    cur = m_cur();
    nxt = m_next();
    ovf = 1'b0;
    udf = 1'b0;
    if (m_ok()) begin
      sz = m_stk.size();
      if (push && pop && sz > 0) m_stk[$] = cur;
      else if (pop && sz > 0) void'(m_stk.pop_back());
      else if (push) begin
        if (sz < STK_DEPTH) m_stk.push_back(cur);
        else ovf = 1'b1;
      end
      if (pop && sz == 0) udf = 1'b1;
      m_ctx[ctx_sel] = nxt;
    end
    m_err = clear_err ? {ovf, udf} : (m_err | {ovf, udf});
    if (cond_valid) m_ct = ref_cond(cond, BYP ? nxt : cur);
    m_ctv = cond_valid;
  endfunction

  task automatic compare();
    chk("flags_out", 8'(flags_out), 8'(BYP ? m_next() : m_cur()));
    chk("stk_level", 8'(stk_level), 8'(m_stk.size()));
    chk("stk_full", 8'(stk_full), 8'(m_stk.size() == STK_DEPTH));
    chk("stk_empty", 8'(stk_empty), 8'(m_stk.size() == 0));
    chk("stk_err", 8'(stk_err), 8'(m_err));
    chk("cond_taken", 8'(cond_taken), 8'(m_ct));
    chk("cond_taken_valid", 8'(cond_taken_valid), 8'(m_ctv));
  endtask

  // inputs are set at the falling edge; outputs checked, then the edge applied
  task automatic step();
    if (rst) model_reset();
    #1 compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic [CTX_W-1:0] s, input logic [3:0] fin, input logic ue,
                       input logic [3:0] msk, input logic ps, input logic pp,
                       input logic [3:0] cc, input logic cv, input logic ce);
    ctx_sel = s; flags_in = fin; upd_en = ue; upd_mask = msk;
    push = ps; pop = pp; cond = cc; cond_valid = cv; clear_err = ce;
  endtask

  task automatic idle(input logic [CTX_W-1:0] s);
    drive(s, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
  endtask

  logic [3:0]  push_vals [5];
  logic [3:0]  pop_exp [4];
  logic [15:0] exp_sweep;

  initial begin
    push_vals = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1100};
    pop_exp   = '{4'b0100, 4'b0010, 4'b0001, 4'b1011};
    exp_sweep = 16'b1110_1001_1001_0110;

    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    idle(1'b0);
    chk("reset_flags", 8'(flags_out), 8'h0);
    chk("reset_empty", 8'(stk_empty), 8'h1);
    chk("reset_err", 8'(stk_err), 8'h0);

    drive(1'b1, 4'b1010, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b1);
    chk("upd_ctx1", 8'(flags_out), 8'b1010);
    idle(1'b0);
    chk("ctx0_untouched", 8'(flags_out), 8'b0000);

    drive(1'b0, 4'b1111, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b1, 4'b0100, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("masked_upd", 8'(flags_out), 8'b1011);

    for (int k = 0; k < 5; k++) begin
      drive(1'b0, push_vals[k], 1'b1, 4'b1111, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      chk("push_level", 8'(stk_level), 8'((k < 4) ? k + 1 : 4));
      chk("push_full", 8'(stk_full), 8'(k >= 3));
    end
    chk("overflow_err", 8'(stk_err), 8'b10);

    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
      step();
      idle(1'b0);
      chk("pop_restore", 8'(flags_out), 8'(pop_exp[k]));
    end
    chk("pop_empty", 8'(stk_empty), 8'h1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("underflow_err", 8'(stk_err), 8'b11);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    step();
    idle(1'b0);
    chk("clear_err", 8'(stk_err), 8'b00);

    drive(1'b0, 4'b1001, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'(c), 1'b1, 1'b0);
      step();
      chk("cond_sweep", 8'(cond_taken), 8'(exp_sweep[c]));
      chk("cond_sweep_valid", 8'(cond_taken_valid), 8'h1);
    end
    idle(1'b0);
    step();
    chk("cond_hold", 8'(cond_taken), 8'h1);
    chk("cond_valid_low", 8'(cond_taken_valid), 8'h0);

    drive(1'b0, 4'b0110, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0011, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("xchg_ctx", 8'(flags_out), 8'b0110);
    chk("xchg_level", 8'(stk_level), 8'h1);
    drive(1'b0, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b1, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("xchg_pop_wins", 8'(flags_out), 8'b0011);
    chk("xchg_level2", 8'(stk_level), 8'h1);
    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
    step();
    idle(1'b0);
    chk("xchg_top", 8'(flags_out), 8'b0110);

    drive(1'b0, 4'b0000, 1'b1, 4'b1111, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    step();
    chk("bypass_eq", 8'(cond_taken), 8'(BYP));

    drive(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle(1'b1);
    chk("midop_rst_flags", 8'(flags_out), 8'h0);
    chk("midop_rst_level", 8'(stk_level), 8'h0);

    for (int n = 0; n < 800; n++) begin
      drive(CTX_W'($urandom_range(NUM_CTX - 1)), 4'($urandom), ($urandom_range(1) == 1),
            4'($urandom), ($urandom_range(2) == 0), ($urandom_range(2) == 0),
            4'($urandom), ($urandom_range(1) == 1), ($urandom_range(15) == 0));
      rst = ($urandom_range(149) == 0);
      step();
    end
    rst = 1'b0;
    idle(1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
